alu_pipelined: RTL and testbench



---
 rtl/alu_pipe_pkg.sv | 25 ++
 rtl/alu_pipe_core.sv | 57 +++++
 rtl/alu_pipelined.sv | 128 ++++++++++++
 tb/tb_alu_pipelined.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and flag bundle for the two-stage pipelined ALU.
package alu_pipe_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result and flags from the registered operands.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shift_value,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             ill;

    always_comb begin
        sum   = {1'b0, input1} + {1'b0, input2};
        diff  = {1'b0, input1} - {1'b0, input2};
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        ill   = 1'b0;
        case (opcode)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra top bit of the difference is the unsigned borrow.
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_AND:  res = input1 & input2;
            OP_OR:   res = input1 | input2;
            OP_SLL:  res = input1 << shift_value;
            OP_XOR:  res = input1 ^ input2;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            OP_NAND: res = ~(input1 & input2);
            OP_SRL:  res = input1 >> shift_value;
            OP_SRA:  res = $signed(input1) >>> shift_value;
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            default: ill = (opcode > OP_LAST_LEGAL);
        endcase
        result = res;
        flags  = '{carry: carry, zero: (res == '0), overflow: ovf, illegal: ill};
    end

endmodule

// File: rtl/alu_pipelined.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Optional sticky carry/overflow flags are enabled by defining ALU_PIPE_STICKY_EN.
module alu_pipelined
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ALU_PIPE_STICKY_EN
    input  logic             stickyClr,
    output logic             carrySticky,
    output logic             ovfSticky,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shiftValue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag,
    output logic             overFlowFlag,
    output logic             illegalFlag
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and a stalled output holds its data.
    logic             s1_valid;
    logic [3:0]       s1_opcode;
    logic [WIDTH-1:0] s1_input1;
    logic [WIDTH-1:0] s1_input2;
    logic [SHW-1:0]   s1_shift;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    alu_flags_t       s2_flags;

    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    logic s1_load;
    logic s2_load;
    logic out_hs;

    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign out_hs   = s2_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_opcode <= '0;
            s1_input1 <= '0;
            s1_input2 <= '0;
            s1_shift  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid  <= 1'b1;
                s1_opcode <= opcode;
                s1_input1 <= input1;
                s1_input2 <= input2;
                s1_shift  <= shiftValue;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .opcode      (s1_opcode),
        .input1      (s1_input1),
        .input2      (s1_input2),
        .shift_value (s1_shift),
        .result      (core_result),
        .flags       (core_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else begin
            if (s2_load) begin
                s2_valid  <= 1'b1;
                s2_result <= core_result;
                s2_flags  <= core_flags;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = s2_valid;
    assign result       = s2_result;
    assign carryFlag    = s2_flags.carry;
    assign zeroFlag     = s2_flags.zero;
    assign overFlowFlag = s2_flags.overflow;
    assign illegalFlag  = s2_flags.illegal;

`ifdef ALU_PIPE_STICKY_EN
    // A set from a handshake takes priority over a concurrent clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carrySticky <= 1'b0;
            ovfSticky   <= 1'b0;
        end else begin
            if (out_hs && s2_flags.carry) begin
                carrySticky <= 1'b1;
            end else if (stickyClr) begin
                carrySticky <= 1'b0;
            end
            if (out_hs && s2_flags.overflow) begin
                ovfSticky <= 1'b1;
            end else if (stickyClr) begin
                ovfSticky <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipelined.sv
// Self-checking bench for alu_pipelined: directed vectors, pipeline corner cases, random stream.
module tb_alu_pipelined;

    localparam int W   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     opcode;
    logic [W-1:0]   input1;
    logic [W-1:0]   input2;
    logic [SHW-1:0] shiftValue;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic           carryFlag;
    logic           zeroFlag;
    logic           overFlowFlag;
    logic           illegalFlag;
`ifdef ALU_PIPE_STICKY_EN
    logic           stickyClr;
    logic           carrySticky;
    logic           ovfSticky;
`endif

    alu_pipelined #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef ALU_PIPE_STICKY_EN
        .stickyClr    (stickyClr),
        .carrySticky  (carrySticky),
        .ovfSticky    (ovfSticky),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .input1       (input1),
        .input2       (input2),
        .shiftValue   (shiftValue),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .carryFlag    (carryFlag),
        .zeroFlag     (zeroFlag),
        .overFlowFlag (overFlowFlag),
        .illegalFlag  (illegalFlag)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_in     = 0;
    int n_out    = 0;
    logic [W+3:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference model: {result, carry, zero, overflow, illegal} from plain 64-bit arithmetic.
    function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [SHW-1:0] sh);
        logic [63:0] ua, ub, tmp;
        longint      sa, sb, ss;
        logic [W-1:0] res;
        logic c, v, il;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        res = '0; c = 1'b0; v = 1'b0; il = 1'b0;
        case (op)
            4'd0: begin
                tmp = ua + ub; res = tmp[W-1:0]; c = (tmp > 64'hFFFF_FFFF);
                ss = sa + sb; v = (ss != longint'($signed(res)));
            end
            4'd1: begin
                res = a - b; c = (ua < ub);
                ss = sa - sb; v = (ss != longint'($signed(res)));
            end
            4'd2:  res = a & b;
            4'd3:  res = a | b;
            4'd4:  res = a << sh;
            4'd5:  res = a ^ b;
            4'd6:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  res = ~(a & b);
            4'd8:  res = a >> sh;
            4'd9:  begin tmp = sa >>> sh; res = tmp[W-1:0]; end
            4'd10: res = (ua < ub) ? 32'd1 : 32'd0;
            default: il = 1'b1;
        endcase
        return {res, c, (res == '0), v, il};
    endfunction

    // ---------------- scoreboard ----------------
    always @(posedge rst) exp_q.delete();

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check("sb_unexpected_output", 1, 0);
                else check("sb_out", {result, carryFlag, zeroFlag, overFlowFlag, illegalFlag},
                           exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back(model(opcode, input1, input2, shiftValue));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Caller sits just after a rising edge; returns just after the accepting edge.
    task automatic stream_op(input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [SHW-1:0] sh);
        bit accepted = 0;
        opcode = op; input1 = a; input2 = b; shiftValue = sh;
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin accepted = 1; break; end
        end
        if (!accepted) check("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SHW-1:0] sh);
        @(posedge clk); #1;
        stream_op(op, a, b, sh);
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [3:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [SHW-1:0] sh;
        logic [W-1:0]   res;
        logic           c, z, v, il;
    } vec_t;

    vec_t vecs[15];
    int   stall_at;
    int   n_in0, n_out0, seen;
    bit   rand_done;

    initial begin
        vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1, 1, 0, 0};
        vecs[1]  = '{4'd1,  32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 0, 0, 1, 0};
        vecs[2]  = '{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 0, 0, 0, 0};
        vecs[3]  = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 0, 1, 0, 0};
        vecs[4]  = '{4'd9,  32'h8000_0000, 32'h0000_0000, 5'd4,  32'hF800_0000, 0, 0, 0, 0};
        vecs[5]  = '{4'd8,  32'h8000_0000, 32'h0000_0000, 5'd4,  32'h0800_0000, 0, 0, 0, 0};
        vecs[6]  = '{4'd4,  32'h0000_0001, 32'h0000_1234, 5'd31, 32'h8000_0000, 0, 0, 0, 0};
        vecs[7]  = '{4'd13, 32'h0000_0005, 32'h0000_0006, 5'd3,  32'h0000_0000, 0, 1, 0, 1};
        vecs[8]  = '{4'd1,  32'h0000_0001, 32'h0000_0002, 5'd0,  32'hFFFF_FFFF, 1, 0, 0, 0};
        vecs[9]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 0, 0, 1, 0};
        vecs[10] = '{4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h0FFF_0FFF, 0, 0, 0, 0};
        vecs[11] = '{4'd5,  32'hAAAA_5555, 32'hFFFF_0000, 5'd0,  32'h5555_5555, 0, 0, 0, 0};
        vecs[12] = '{4'd3,  32'h0000_000F, 32'h0000_00F0, 5'd0,  32'h0000_00FF, 0, 0, 0, 0};
        vecs[13] = '{4'd1,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 0, 1, 0, 0};
        vecs[14] = '{4'd9,  32'h4000_0000, 32'h0000_0000, 5'd4,  32'h0400_0000, 0, 0, 0, 0};

        // ---------------- reset ----------------
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; input1 = '0; input2 = '0; shiftValue = '0;
`ifdef ALU_PIPE_STICKY_EN
        stickyClr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {result, carryFlag, zeroFlag, overFlowFlag, illegalFlag}, 0);
`ifdef ALU_PIPE_STICKY_EN
        check("rst_sticky", {carrySticky, ovfSticky}, 0);
`endif
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // ---------------- directed vectors with latency ----------------
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            @(negedge clk);
            check($sformatf("vec%0d_latency_early", i), out_valid, 0);
            @(negedge clk);
            check($sformatf("vec%0d_out_valid", i), out_valid, 1);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_flags", i), {carryFlag, zeroFlag, overFlowFlag, illegalFlag},
                  {vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].il});
        end

        // ---------------- back-pressure ----------------
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_in0 = n_in; n_out0 = n_out; stall_at = -1;
        fork
            begin
                for (int i = 0; i < 6; i++) stream_op(4'd0, i, i + 1, '0);
                in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 5; t++) begin
                    @(negedge clk);
                    if (!in_ready && stall_at < 0) stall_at = n_in - n_in0;
                end
                @(posedge clk); #1 out_ready = 1'b1;
                seen = 0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (out_valid) seen++;
                end
                check("bp_stall_after_accepts", stall_at, 2);
                check("bp_one_per_cycle", seen, 6);
            end
        join
        repeat (3) @(negedge clk);
        check("bp_output_count", n_out - n_out0, 6);
        check("bp_queue_empty", exp_q.size(), 0);

        // ---------------- reset with both stages full ----------------
        out_ready = 1'b0;
        send(4'd0, 32'd10, 32'd20, '0);
        send(4'd1, 32'd50, 32'd7, '0);
        repeat (2) @(negedge clk);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        @(posedge clk); #1 rst = 1'b1;
        #1 check("rst_mid_out_valid", out_valid, 0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        n_out0 = n_out; seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_stale_output", seen, 0);
        check("rst_mid_in_ready", in_ready, 1);

`ifdef ALU_PIPE_STICKY_EN
        // ---------------- sticky flags ----------------
        send(4'd0, 32'h7FFF_FFFF, 32'h1, '0);
        repeat (3) @(negedge clk);
        check("sticky_ovf_set", ovfSticky, 1);
        check("sticky_carry_clear", carrySticky, 0);
        send(4'd0, 32'h8000_0000, 32'h8000_0000, '0);
        @(negedge clk);
        @(negedge clk);
        stickyClr = 1'b1;
        @(posedge clk); #1 stickyClr = 1'b0;
        check("sticky_set_wins_ovf", ovfSticky, 1);
        check("sticky_set_wins_carry", carrySticky, 1);
        @(posedge clk); #1 stickyClr = 1'b1;
        @(posedge clk); #1 stickyClr = 1'b0;
        check("sticky_cleared", {carrySticky, ovfSticky}, 0);
`endif

        // ---------------- random stream with random back-pressure ----------------
        n_in0 = n_in; n_out0 = n_out; rand_done = 0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 300; i++)
                    stream_op(4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
                              SHW'($urandom_range(0, W - 1)));
                in_valid = 1'b0;
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        check("rand_drained", exp_q.size(), 0);
        check("rand_in_out_count", n_out - n_out0, n_in - n_in0);
        check("rand_accept_count", n_in - n_in0, 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
